wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports: clk input 1, clock, all state updates on its rising edge.
REQ-002 SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-003 SHALL have alu_valid input 1, ALU-side writeback request.
REQ-004 SHALL have alu_ready output 1, ALU request accepted this cycle when high with alu_valid.
REQ-005 SHALL have alu_rd input 5, destination register.
REQ-006 SHALL have alu_data input arch_reg (32), ALU result.
REQ-007 SHALL have alu_pc input arch_reg, instruction PC.
REQ-008 SHALL have alu_sel input write_back_select_t, source select.
REQ-009 SHALL have mem_valid input 1, load response; cannot be back-pressured.
REQ-010 SHALL have mem_rd input 5 and mem_data input arch_reg, load destination and data.
REQ-011 SHALL have rf_we output 1, rf_rd output 5, rf_wdata output arch_reg: registered register-file write port.
REQ-012 SHALL have busy output 1, high when FIFO non-empty or rf_we high.

Function
REQ-013 SHALL resolve ALU data at acceptance: WRITE_BACK_SEL_PC -> alu_pc+4 (mod 2^32); WRITE_BACK_SEL_ALU, WRITE_BACK_SEL_MEM or any other code -> alu_data.
REQ-014 SHALL buffer accepted ALU requests (rd, resolved data) in a 2-entry FIFO, count 0..2.
REQ-015 SHALL drive alu_ready = (count < 2), independent of same-cycle pop.
REQ-016 SHALL write port per cycle: mem_valid -> register mem request; else FIFO non-empty -> pop head and register it; else rf_we=0.
REQ-017 SHALL give mem absolute priority; FIFO head holds while mem_valid is high, with no entry loss or duplication.
REQ-018 SHALL have latency of exactly 1 cycle from mem_valid to rf_we, and at least 1 cycle from ALU acceptance to rf_we when unobstructed.
REQ-019 SHALL treat rd==0 requests as consumed normally but with rf_we=0 in the write cycle.
REQ-020 SHALL support simultaneous push and pop in one cycle; count unchanged.
REQ-021 SHALL retire ALU entries in acceptance order; ordering between mem and ALU requests is not preserved, and upstream guarantees no same-rd overlap.
REQ-022 SHALL wrap FIFO pointers modulo 2.

Reset
REQ-023 SHALL asynchronously clear count, pointers, rf_we, rf_rd, rf_wdata to 0 on rst_n low; alu_ready=1 and busy=0 once reset is released.
REQ-024 SHALL discard buffered entries when reset is asserted mid-operation; no write after release until a new request arrives.

Configuration
REQ-025 SHALL, with WB_STALL_CNT_EN defined, add output stall_cnt 32, counting cycles with alu_valid=1 and alu_ready=0, saturating at 0xFFFFFFFF and cleared by reset.
REQ-026 SHALL, without WB_STALL_CNT_EN, omit the port and the counter entirely.

Structure
REQ-027 SHALL keep write_back_select_t and its codes in write_back_pkg, and FIFO depth constant WB_FIFO_DEPTH=2 in the same package.
REQ-028 SHALL implement the buffer as sub-module wb_fifo (push/pop/full/empty, parameterised width).

Verification
REQ-029 SHALL cover ALU-only: alu_valid, rd=5, data=0x1234, sel=ALU -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234.
REQ-030 SHALL cover PC link: sel=PC, alu_pc=0xFFFFFFFC, rd=1 -> rf_wdata=0x00000000.
REQ-031 SHALL cover priority: ALU rd=3 buffered; mem_valid for 3 cycles, rd=7 -> three mem writes first, then rd=3 write; alu_ready=0 once 2 entries are held.
REQ-032 SHALL cover rd=0: ALU rd=0 accepted -> rf_we stays 0, count returns to 0.
REQ-033 SHALL cover reset mid-operation: 2 entries buffered, rst_n pulsed low -> rf_we=0, alu_ready=1, no stale writes afterwards.
REQ-034 SHALL cover the counter (WB_STALL_CNT_EN): hold alu_valid with FIFO full under mem_valid for 4 cycles -> stall_cnt=4.

Source files
------------

// File: rtl/write_back_pkg.sv
// Shared types and constants for the writeback arbiter: the architectural
// register type, the writeback source-select codes, the buffered ALU entry
// layout, the writeback FIFO depth and the ALU result-resolution helper.
package write_back_pkg;

    localparam int ARCH_W        = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int WB_FIFO_DEPTH = 2;

    typedef logic [ARCH_W-1:0] arch_reg;

    typedef enum logic [1:0] {
        WRITE_BACK_SEL_ALU = 2'd0,
        WRITE_BACK_SEL_MEM = 2'd1,
        WRITE_BACK_SEL_PC  = 2'd2
    } write_back_select_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        arch_reg               data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

    // Link writes (PC select) store the return address; every other code,
    // including unused ones, stores the ALU result unchanged.
    function automatic arch_reg resolve_alu_data(input write_back_select_t sel,
                                                 input arch_reg            data,
                                                 input arch_reg            pc);
        arch_reg res;
        if (sel == WRITE_BACK_SEL_PC) res = pc + arch_reg'(4);
        else                          res = data;
        return res;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding accepted ALU writeback entries.
// Pointers wrap modulo DEPTH; storage is not reset, only control state.
module wb_fifo
    import write_back_pkg::*;
#(
    parameter int WIDTH = WB_ENTRY_W,
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state: cleared asynchronously, which also discards any entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results (buffered, back-pressurable) and load
// responses (never stalled, absolute priority) onto one registered
// register-file write port. Writes to x0 are consumed but never asserted.
// Optional feature: define WB_STALL_CNT_EN to add the stall_cnt output, a
// saturating count of cycles in which the ALU request was back-pressured.
module wb_arbiter
    import write_back_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [ARCH_W-1:0]     alu_data,
    input  logic [ARCH_W-1:0]     alu_pc,
    input  write_back_select_t    alu_sel,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [ARCH_W-1:0]     mem_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [ARCH_W-1:0]     rf_wdata,
`ifdef WB_STALL_CNT_EN
    output logic                  busy,
    output logic [31:0]           stall_cnt
`else
    output logic                  busy
`endif
);

    logic                  alu_accept;
    wb_entry_t             alu_entry;
    wb_entry_t             fifo_head;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                  wr_valid;
    wb_entry_t             wr_entry;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [ARCH_W-1:0]     rf_wdata_q, rf_wdata_d;

    assign alu_ready       = !fifo_full;
    assign alu_accept      = alu_valid && alu_ready;
    assign alu_entry.rd    = alu_rd;
    assign alu_entry.data  = resolve_alu_data(alu_sel, alu_data, alu_pc);

    wb_fifo #(
        .WIDTH (WB_ENTRY_W),
        .DEPTH (WB_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (alu_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pick this cycle's write: load first, then FIFO head, then a fresh ALU
    // request straight through when nothing is queued ahead of it.
    always_comb begin
        wr_valid   = 1'b0;
        wr_entry   = '0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        if (mem_valid) begin
            wr_valid      = 1'b1;
            wr_entry.rd   = mem_rd;
            wr_entry.data = mem_data;
            fifo_push     = alu_accept;
        end else if (!fifo_empty) begin
            wr_valid  = 1'b1;
            wr_entry  = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = alu_accept;
        end else if (alu_accept) begin
            wr_valid = 1'b1;
            wr_entry = alu_entry;
        end
        rf_we_d    = wr_valid && (wr_entry.rd != '0);
        rf_rd_d    = wr_valid ? wr_entry.rd   : rf_rd_q;
        rf_wdata_d = wr_valid ? wr_entry.data : rf_wdata_q;
    end

    // Registered register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = !fifo_empty || rf_we_q;

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count back-pressured ALU cycles, sticking at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (alu_valid && !alu_ready && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model of the writeback rules.
module tb_wb_arbiter;
    import write_back_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               alu_valid;
    logic               alu_ready;
    logic [4:0]         alu_rd;
    logic [31:0]        alu_data;
    logic [31:0]        alu_pc;
    write_back_select_t alu_sel;
    logic               mem_valid;
    logic [4:0]         mem_rd;
    logic [31:0]        mem_data;
    logic               rf_we;
    logic [4:0]         rf_rd;
    logic [31:0]        rf_wdata;
    logic               busy;
`ifdef WB_STALL_CNT_EN
    logic [31:0]        stall_cnt;
`endif

    wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_pc    (alu_pc),
        .alu_sel   (alu_sel),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
`ifdef WB_STALL_CNT_EN
        .busy      (busy),
        .stall_cnt (stall_cnt)
`else
        .busy      (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending ALU writes in acceptance order.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        exp_ready, obs_ready;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;
    logic        exp_busy;
    int          passed = 0;
    int          total  = 0;

    // One clock of stimulus: apply inputs mid-cycle, record alu_ready, apply
    // the writeback rules to the model, then advance past the rising edge.
    task automatic cycle(input logic av, input logic [4:0] ard,
                         input logic [31:0] adata, input logic [31:0] apc,
                         input logic [1:0] asel, input logic mv,
                         input logic [4:0] mrd, input logic [31:0] mdata);
        ent_t e;
        @(negedge clk);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adata;
        alu_pc    = apc;
        alu_sel   = write_back_select_t'(asel);
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = mdata;
        #1;
        obs_ready = alu_ready;
        exp_ready = (q.size() < 2);
        if (av && exp_ready) begin
            e.rd   = ard;
            e.data = (asel == 2'd2) ? apc + 32'd4 : adata;
            q.push_back(e);
        end
        if (mv) begin
            exp_we    = (mrd != 5'd0);
            exp_rd    = mrd;
            exp_wdata = mdata;
        end else if (q.size() > 0) begin
            e         = q.pop_front();
            exp_we    = (e.rd != 5'd0);
            exp_rd    = e.rd;
            exp_wdata = e.data;
        end else begin
            exp_we = 1'b0;
        end
        exp_busy = (q.size() != 0) || exp_we;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0; alu_pc = '0;
        alu_sel = WRITE_BACK_SEL_ALU; mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got=%b want=0", rf_we); else passed++;
        total++; if (rf_rd !== 5'd0) $display("FAIL reset_rf_rd got=%0d want=0", rf_rd); else passed++;
        total++; if (rf_wdata !== 32'd0) $display("FAIL reset_rf_wdata got=%h want=0", rf_wdata); else passed++;
        @(negedge clk) rst_n = 1'b1;
        #1;
        total++; if (alu_ready !== 1'b1) $display("FAIL reset_alu_ready got=%b want=1", alu_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
        q.delete();
        exp_we = 1'b0;
        idle();
        total++; if (rf_we !== 1'b0) $display("FAIL reset_idle_we got=%b want=0", rf_we); else passed++;
    endtask

    task automatic test_alu_only();
        cycle(1'b1, 5'd5, 32'h1234, 32'h100, 2'd0, 1'b0, 5'd0, 32'd0);
        total++; if (obs_ready !== 1'b1) $display("FAIL alu_only_ready got=%b want=1", obs_ready); else passed++;
        total++; if (rf_we !== 1'b1) $display("FAIL alu_only_we got=%b want=1", rf_we); else passed++;
        total++; if (rf_rd !== 5'd5) $display("FAIL alu_only_rd got=%0d want=5", rf_rd); else passed++;
        total++; if (rf_wdata !== 32'h1234) $display("FAIL alu_only_wdata got=%h want=00001234", rf_wdata); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL alu_only_busy got=%b want=1", busy); else passed++;
        idle();
        total++; if (rf_we !== 1'b0) $display("FAIL alu_only_after_we got=%b want=0", rf_we); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL alu_only_after_busy got=%b want=0", busy); else passed++;
    endtask

    task automatic test_sel_codes();
        cycle(1'b1, 5'd1, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 2'd2, 1'b0, 5'd0, 32'd0);
        total++; if (rf_we !== 1'b1) $display("FAIL pc_link_we got=%b want=1", rf_we); else passed++;
        total++; if (rf_wdata !== 32'h0) $display("FAIL pc_link_wdata got=%h want=00000000", rf_wdata); else passed++;
        cycle(1'b1, 5'd2, 32'hCAFE_0001, 32'h0000_1000, 2'd1, 1'b0, 5'd0, 32'd0);
        total++; if (rf_wdata !== 32'hCAFE_0001) $display("FAIL sel_mem_wdata got=%h want=cafe0001", rf_wdata); else passed++;
        cycle(1'b1, 5'd3, 32'hCAFE_0002, 32'h0000_1000, 2'd3, 1'b0, 5'd0, 32'd0);
        total++; if (rf_wdata !== 32'hCAFE_0002) $display("FAIL sel_other_wdata got=%h want=cafe0002", rf_wdata); else passed++;
        idle();
    endtask

    task automatic test_priority();
        cycle(1'b1, 5'd3, 32'h33, 32'd0, 2'd0, 1'b1, 5'd7, 32'h70);
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h70)
            $display("FAIL prio_mem0 got=%b/%0d/%h want=1/7/00000070", rf_we, rf_rd, rf_wdata); else passed++;
        cycle(1'b1, 5'd4, 32'h44, 32'd0, 2'd0, 1'b1, 5'd7, 32'h71);
        total++; if (obs_ready !== 1'b1) $display("FAIL prio_ready_one got=%b want=1", obs_ready); else passed++;
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h71)
            $display("FAIL prio_mem1 got=%b/%0d/%h want=1/7/00000071", rf_we, rf_rd, rf_wdata); else passed++;
        total++; if (alu_ready !== 1'b0) $display("FAIL prio_full_ready got=%b want=0", alu_ready); else passed++;
        cycle(1'b1, 5'd9, 32'h99, 32'd0, 2'd0, 1'b1, 5'd7, 32'h72);
        total++; if (obs_ready !== 1'b0) $display("FAIL prio_ready_full got=%b want=0", obs_ready); else passed++;
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h72)
            $display("FAIL prio_mem2 got=%b/%0d/%h want=1/7/00000072", rf_we, rf_rd, rf_wdata); else passed++;
        idle();
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h33)
            $display("FAIL prio_alu3 got=%b/%0d/%h want=1/3/00000033", rf_we, rf_rd, rf_wdata); else passed++;
        idle();
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h44)
            $display("FAIL prio_alu4 got=%b/%0d/%h want=1/4/00000044", rf_we, rf_rd, rf_wdata); else passed++;
        idle();
        total++; if (rf_we !== 1'b0 || busy !== 1'b0) $display("FAIL prio_drained got=%b/%b want=0/0", rf_we, busy); else passed++;
    endtask

    task automatic test_rd_zero();
        cycle(1'b1, 5'd0, 32'h5555, 32'd0, 2'd0, 1'b0, 5'd0, 32'd0);
        total++; if (rf_we !== 1'b0) $display("FAIL rd0_direct_we got=%b want=0", rf_we); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rd0_direct_busy got=%b want=0", busy); else passed++;
        cycle(1'b1, 5'd0, 32'h6666, 32'd0, 2'd0, 1'b1, 5'd8, 32'h88);
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd8) $display("FAIL rd0_mem_we got=%b/%0d want=1/8", rf_we, rf_rd); else passed++;
        idle();
        total++; if (rf_we !== 1'b0) $display("FAIL rd0_queued_we got=%b want=0", rf_we); else passed++;
        total++; if (busy !== 1'b0 || alu_ready !== 1'b1)
            $display("FAIL rd0_count_empty got=%b/%b want=0/1", busy, alu_ready); else passed++;
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 5'd12, 32'hC, 32'd0, 2'd0, 1'b1, 5'd20, 32'h20);
        cycle(1'b1, 5'd13, 32'hD, 32'd0, 2'd0, 1'b1, 5'd21, 32'h21);
        total++; if (alu_ready !== 1'b0) $display("FAIL rstmid_full got=%b want=0", alu_ready); else passed++;
        @(negedge clk);
        alu_valid = 1'b0; mem_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (rf_we !== 1'b0) $display("FAIL rstmid_we got=%b want=0", rf_we); else passed++;
        total++; if (alu_ready !== 1'b1) $display("FAIL rstmid_ready got=%b want=1", alu_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy); else passed++;
        q.delete();
        exp_we = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            total++; if (rf_we !== 1'b0) $display("FAIL rstmid_stale_we cycle=%0d got=%b want=0", i, rf_we); else passed++;
        end
    endtask

`ifdef WB_STALL_CNT_EN
    task automatic test_stall_cnt();
        total++; if (stall_cnt !== 32'd0) $display("FAIL stall_start got=%0d want=0", stall_cnt); else passed++;
        cycle(1'b1, 5'd10, 32'hA, 32'd0, 2'd0, 1'b1, 5'd22, 32'h22);
        cycle(1'b1, 5'd11, 32'hB, 32'd0, 2'd0, 1'b1, 5'd22, 32'h23);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'd14, 32'hE, 32'd0, 2'd0, 1'b1, 5'd22, 32'h24);
        total++; if (stall_cnt !== 32'd4) $display("FAIL stall_count got=%0d want=4", stall_cnt); else passed++;
        repeat (3) idle();
        total++; if (stall_cnt !== 32'd4) $display("FAIL stall_hold got=%0d want=4", stall_cnt); else passed++;
    endtask
`endif

    task automatic test_random();
        logic        av, mv;
        logic [4:0]  ard, mrd;
        logic [1:0]  asel;
        logic [31:0] adata, apc, mdata;
        for (int i = 0; i < 400; i++) begin
            av    = ($urandom_range(0, 99) < 60);
            mv    = ($urandom_range(0, 99) < 35);
            ard   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mrd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            asel  = 2'($urandom_range(0, 3));
            adata = $urandom;
            apc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            mdata = $urandom;
            cycle(av, ard, adata, apc, asel, mv, mrd, mdata);
            total++; if (obs_ready !== exp_ready) $display("FAIL rand_ready i=%0d got=%b want=%b", i, obs_ready, exp_ready); else passed++;
            total++; if (rf_we !== exp_we) $display("FAIL rand_we i=%0d got=%b want=%b", i, rf_we, exp_we); else passed++;
            if (exp_we) begin
                total++; if (rf_rd !== exp_rd || rf_wdata !== exp_wdata)
                    $display("FAIL rand_data i=%0d got=%0d/%h want=%0d/%h", i, rf_rd, rf_wdata, exp_rd, exp_wdata); else passed++;
            end
            total++; if (busy !== exp_busy) $display("FAIL rand_busy i=%0d got=%b want=%b", i, busy, exp_busy); else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            total++; if (rf_we !== exp_we) $display("FAIL rand_drain_we i=%0d got=%b want=%b", i, rf_we, exp_we); else passed++;
            total++; if (busy !== exp_busy) $display("FAIL rand_drain_busy i=%0d got=%b want=%b", i, busy, exp_busy); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_sel_codes();
        test_priority();
        test_rd_zero();
        test_reset_mid();
`ifdef WB_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
